// File: rtl/layer_seq.sv
// layer_seq: fully-connected layer of N_OUT neurons over N_IN inputs,
// evaluated by one shared 9x10 multiplier and 8-bit accumulator.
module layer_seq #(
   parameter int N_IN  = 10,
   parameter int N_OUT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [9*N_IN-1:0]    in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [8*N_OUT-1:0]   out_data_o,
   input  logic                 cfg_we_i,
   input  logic [7:0]           cfg_addr_i,
   input  logic [9:0]           cfg_wdata_i,
   output logic                 cfg_ready_o
);
   localparam int KW = N_IN > 1 ? $clog2(N_IN) : 1;
   localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
   typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;
   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [JW-1:0] j_q, j_d;
   logic [7:0]    acc_q, acc_d;
   logic [8:0]    in_v [N_IN];
   logic [8:0]    in_q [N_IN];
   logic [9:0]    w_q [N_OUT][N_IN];
   logic [7:0]    b_q [N_OUT];
   logic [7:0]    o_q [N_OUT];
   logic [17:0]   prod;
   logic [7:0]    sum;
   logic          accept, cfg_ok;
   genvar i;
   for (i = 0; i < N_IN; i++) begin : g_in
      assign in_v[i] = in_data_i[9*i +: 9];
   end
   for (i = 0; i < N_OUT; i++) begin : g_out
      assign out_data_o[8*i +: 8] = o_q[i];
   end
   assign in_ready_o  = state_q == IDLE;
   assign cfg_ready_o = state_q == IDLE;
   assign out_valid_o = state_q == DONE;
   assign accept      = in_valid_i && in_ready_o;
   assign cfg_ok      = cfg_we_i && cfg_ready_o;
   // Product kept modulo 2^18; only bits [17:10] reach the accumulator.
   assign prod = 18'($signed(in_q[k_q])) * 18'($signed(w_q[j_q][k_q]));
   assign sum  = acc_q + b_q[j_q];
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      j_d     = j_q;
      acc_d   = acc_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = MAC;
            k_d     = '0;
            j_d     = '0;
            acc_d   = '0;
         end
         MAC: begin
            acc_d   = acc_q + 8'(prod >> 10);
            k_d     = k_q + KW'(1);
            state_d = k_q == KW'(N_IN-1) ? BIAS : MAC;
         end
         BIAS: begin
            acc_d   = '0;
            k_d     = '0;
            j_d     = j_q + JW'(1);
            state_d = j_q == JW'(N_OUT-1) ? DONE : MAC;
         end
         DONE: state_d = out_ready_i ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         for (int a = 0; a < N_OUT; a++) o_q[a] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         if (state_q == BIAS) o_q[j_q] <= sum;
      end
   end
   always_ff @(posedge clk) begin
      if (accept) in_q <= in_v;
   end
   // Exact address decode: anything past the last bias matches no register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < N_OUT; a++) begin
            b_q[a] <= '0;
            for (int c = 0; c < N_IN; c++) w_q[a][c] <= '0;
         end
      end else if (cfg_ok) begin
         for (int a = 0; a < N_OUT; a++) begin
            if (cfg_addr_i == 8'(N_IN*N_OUT+a)) b_q[a] <= cfg_wdata_i[7:0];
            for (int c = 0; c < N_IN; c++)
               if (cfg_addr_i == 8'(a*N_IN+c)) w_q[a][c] <= cfg_wdata_i;
         end
      end
   end
endmodule

// File: tb/tb_layer_seq.sv
// tb_layer_seq: table vectors plus corner sequences for layer_seq, checked via a scoreboard queue.
module tb_layer_seq;
   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cfg_we = 0;
   logic        in_ready, out_valid, cfg_ready;
   logic [89:0] in_data = '0;
   logic [31:0] out_data;
   logic [7:0]  cfg_addr = '0;
   logic [9:0]  cfg_wdata = '0;
   logic [31:0] drv_exp = '0;
   logic        prev_ov = 0;
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   int          rise_q[$];
   typedef struct {
      logic [7:0] wa0; logic [9:0] wd0;
      logic [7:0] wa1; logic [9:0] wd1;
      int xi0; logic [8:0] xv0;
      int xi1; logic [8:0] xv1;
      logic [31:0] exp;
   } vec_t;
   typedef struct { logic [31:0] d; int c; } sb_t;
   sb_t  sbq[$];
   sb_t  e;
   vec_t tbl[6];

   always #5 clk = ~clk;

   layer_seq dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
      .cfg_ready_o(cfg_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) sbq.push_back('{drv_exp, cyc + 1});
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (!rst_n) prev_ov <= 0;
      else begin
         if (out_valid && !prev_ov) begin
            rise_q.push_back(cyc);
            if (sbq.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
               e = sbq.pop_front();
               chk("out_data", out_data, e.d);
               chk("latency", cyc - e.c, 44);
            end
         end
         prev_ov <= out_valid;
      end
   end

   function automatic logic [89:0] mk(input int i0, input logic [8:0] v0, input int i1, input logic [8:0] v1);
      mk = '0;
      mk[9*i0 +: 9] = v0;
      mk[9*i1 +: 9] = v1;
   endfunction

   task automatic do_reset;
      @(negedge clk);
      rst_n = 0; in_valid = 0; cfg_we = 0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_out_data", out_data, 0);
      sbq.delete();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic cfg(input logic [7:0] a, input logic [9:0] d);
      @(negedge clk);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk);
      cfg_we = 0;
   endtask

   task automatic send(input logic [89:0] x, input logic [31:0] ex);
      @(negedge clk);
      in_data = x; drv_exp = ex; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_out(input int lim);
      int n = 0;
      while (!out_valid && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) chk("out_valid_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'd0,  10'h0DB, 8'd40,  10'h00A, 0, 9'd64,  1, 9'd0,   32'h0000_0017};
      tbl[1] = '{8'd10, 10'h3E5, 8'd255, 10'h3FF, 0, 9'd100, 1, 9'd0,   32'h0000_FD00};
      tbl[2] = '{8'd0,  10'h200, 8'd44,  10'h3FF, 0, 9'h100, 1, 9'd0,   32'h0000_0080};
      tbl[3] = '{8'd43, 10'h3C5, 8'd39,  10'h1FF, 9, 9'h1FF, 0, 9'd0,   32'hC400_0000};
      tbl[4] = '{8'd25, 10'h0FF, 8'd24,  10'h1FF, 5, 9'h0FF, 4, 9'h100, 32'h00BF_0000};
      tbl[5] = '{8'd0,  10'h1FF, 8'd1,   10'h1FF, 0, 9'h0FF, 1, 9'h0FF, 32'h0000_00FE};
      for (int v = 0; v < 6; v++) begin
         do_reset();
         out_ready = 1;
         cfg(tbl[v].wa0, tbl[v].wd0);
         cfg(tbl[v].wa1, tbl[v].wd1);
         send(mk(tbl[v].xi0, tbl[v].xv0, tbl[v].xi1, tbl[v].xv1), tbl[v].exp);
         wait_out(60);
         @(negedge clk);
      end

      // DONE hold: output stable, inputs and config writes ignored
      do_reset();
      cfg(8'd0, 10'h0DB);
      cfg(8'd40, 10'h00A);
      out_ready = 0;
      send(mk(0, 9'd64, 1, 9'd0), 32'h17);
      chk("busy_in_ready", in_ready, 0);
      chk("busy_cfg_ready", cfg_ready, 0);
      wait_out(60);
      repeat (20) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, 32'h17);
         chk("hold_in_ready", in_ready, 0);
         in_valid = 1; in_data = {$urandom, $urandom, $urandom}; drv_exp = 32'hDEAD_BEEF;
         cfg_we = 1; cfg_addr = 8'd0; cfg_wdata = 10'h000;
         @(negedge clk);
      end
      in_valid = 0; cfg_we = 0; out_ready = 1;
      @(negedge clk);
      chk("release_valid", out_valid, 0);
      chk("release_in_ready", in_ready, 1);

      // same-cycle bias write and handshake; older neurons keep prior output
      @(negedge clk);
      cfg_we = 1; cfg_addr = 8'd40; cfg_wdata = 10'h014;
      in_valid = 1; in_data = mk(0, 9'd64, 1, 9'd0); drv_exp = 32'h21;
      @(negedge clk);
      cfg_we = 0; in_valid = 0;
      repeat (4) @(negedge clk);
      chk("prev_kept", out_data, 32'h17);
      wait_out(60);
      @(negedge clk);

      // reset in the middle of MAC
      send(mk(0, 9'd64, 1, 9'd0), 32'h21);
      repeat (14) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_cfg_ready", cfg_ready, 1);
      sbq.delete();
      @(negedge clk);
      rst_n = 1;
      repeat (60) @(negedge clk);
      chk("post_rst_data", out_data, 0);
      chk("post_rst_valid", out_valid, 0);
      send(mk(0, 9'd64, 1, 9'd0), 32'h0);
      wait_out(60);
      @(negedge clk);
      cfg(8'd0, 10'h0DB);
      cfg(8'd40, 10'h00A);
      send(mk(0, 9'd64, 1, 9'd0), 32'h17);
      wait_out(60);
      @(negedge clk);

      // back-to-back throughput
      begin
         int n = 0;
         rise_q.delete();
         out_ready = 1;
         in_data = mk(0, 9'd64, 1, 9'd0); drv_exp = 32'h17; in_valid = 1;
         while (rise_q.size() < 3 && n < 300) begin
            @(negedge clk);
            n++;
         end
         in_valid = 0;
         if (rise_q.size() < 3) chk("b2b_timeout", rise_q.size(), 3);
         else begin
            chk("b2b_gap1", rise_q[1] - rise_q[0], 46);
            chk("b2b_gap2", rise_q[2] - rise_q[1], 46);
         end
         repeat (60) @(negedge clk);
         chk("sb_drained", sbq.size(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
